// File: rtl/bp_table_ctrl.sv
// Branch-predictor pattern-table controller: init sweep, lookup-priority arbitration, queued 2-bit updates.
// Optional macro BP_TABLE_BYPASS_EN forwards the pending write value to a matching lookup during WRITE.
module bp_table_ctrl #(
  parameter int IDX_W      = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          upd_valid,
  input  logic [IDX_W-1:0]              upd_idx,
  input  logic                          upd_taken,
  output logic                          upd_ready,
  input  logic                          lookup_valid,
  input  logic [IDX_W-1:0]              lookup_idx,
  output logic                          lookup_rvalid,
  output logic [1:0]                    lookup_data,
  output logic                          tbl_en,
  output logic                          tbl_we,
  output logic [IDX_W-1:0]              tbl_addr,
  output logic [1:0]                    tbl_wdata,
  input  logic [1:0]                    tbl_rdata,
  output logic                          init_busy,
  output logic [$clog2(FIFO_DEPTH):0]   pending
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic [IDX_W-1:0] fifo_idx_q [FIFO_DEPTH];
  logic [IDX_W-1:0] fifo_idx_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_taken_q, fifo_taken_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       upd_val_q, upd_val_d;
  logic             rvalid_q, rvalid_d;
  logic             bypass_q;

  logic             push, pop;
  logic             en_c, we_c;
  logic [IDX_W-1:0] addr_c;
  logic [1:0]       wdata_c;
  logic [1:0]       sat_val;
  logic [IDX_W-1:0] head_idx;
  logic             head_taken;

  assign head_idx   = fifo_idx_q[rd_ptr_q];
  assign head_taken = fifo_taken_q[rd_ptr_q];

  always_comb begin
    if (head_taken) sat_val = (tbl_rdata == 2'b11) ? 2'b11 : tbl_rdata + 2'd1;
    else            sat_val = (tbl_rdata == 2'b00) ? 2'b00 : tbl_rdata - 2'd1;
  end

  // Lookups always win the table port outside INIT; the update path only uses idle cycles.
  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    upd_val_d = upd_val_q;
    rvalid_d  = 1'b0;
    pop       = 1'b0;
    en_c      = 1'b0;
    we_c      = 1'b0;
    addr_c    = '0;
    wdata_c   = 2'b00;
    if (state_q == ST_INIT) begin
      en_c    = 1'b1;
      we_c    = 1'b1;
      addr_c  = sweep_q;
      wdata_c = 2'b10;
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == {IDX_W{1'b1}}) state_d = ST_IDLE;
    end else begin
      if (lookup_valid) begin
        en_c     = 1'b1;
        addr_c   = lookup_idx;
        rvalid_d = 1'b1;
      end
      case (state_q)
        ST_IDLE: if (!lookup_valid && count_q != '0) begin
          en_c    = 1'b1;
          addr_c  = head_idx;
          state_d = ST_READ;
        end
        ST_READ: begin
          upd_val_d = sat_val;
          if (!lookup_valid) begin
            en_c    = 1'b1;
            we_c    = 1'b1;
            addr_c  = head_idx;
            wdata_c = sat_val;
            pop     = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WRITE;
          end
        end
        ST_WRITE: if (!lookup_valid) begin
          en_c    = 1'b1;
          we_c    = 1'b1;
          addr_c  = head_idx;
          wdata_c = upd_val_q;
          pop     = 1'b1;
          state_d = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  // Fullness is judged before this cycle's pop, so a pop never frees a slot for a same-cycle push.
  always_comb begin
    push         = upd_valid && (count_q != FULL_CNT);
    fifo_idx_d   = fifo_idx_q;
    fifo_taken_d = fifo_taken_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    if (push) begin
      fifo_idx_d[wr_ptr_q]   = upd_idx;
      fifo_taken_d[wr_ptr_q] = upd_taken;
      wr_ptr_d               = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      sweep_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_idx_q[i] <= '0;
      fifo_taken_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      upd_val_q    <= 2'b00;
      rvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      fifo_idx_q   <= fifo_idx_d;
      fifo_taken_q <= fifo_taken_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      upd_val_q    <= upd_val_d;
      rvalid_q     <= rvalid_d;
    end
  end

`ifdef BP_TABLE_BYPASS_EN
  logic bypass_d;
  always_comb bypass_d = lookup_valid && (state_q == ST_WRITE) && (lookup_idx == head_idx);
  always_ff @(posedge clk) begin
    if (rst) bypass_q <= 1'b0;
    else     bypass_q <= bypass_d;
  end
`else
  assign bypass_q = 1'b0;
`endif

  // The table port is held idle while reset is asserted so the sweep starts cleanly afterwards.
  assign tbl_en        = en_c && !rst;
  assign tbl_we        = we_c && !rst;
  assign tbl_addr      = addr_c;
  assign tbl_wdata     = wdata_c;
  assign upd_ready     = (count_q != FULL_CNT);
  assign pending       = count_q;
  assign init_busy     = (state_q == ST_INIT);
  assign lookup_rvalid = rvalid_q;
  assign lookup_data   = !rvalid_q ? 2'b00 : (bypass_q ? upd_val_q : tbl_rdata);

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Directed bench for bp_table_ctrl with a behavioural synchronous single-port table.
// Honours BP_TABLE_BYPASS_EN when choosing the expected lookup value during WRITE.
module tb_bp_table_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       upd_valid = 1'b0;
  logic [5:0] upd_idx = '0;
  logic       upd_taken = 1'b0;
  logic       upd_ready;
  logic       lookup_valid = 1'b0;
  logic [5:0] lookup_idx = '0;
  logic       lookup_rvalid;
  logic [1:0] lookup_data;
  logic       tbl_en, tbl_we;
  logic [5:0] tbl_addr;
  logic [1:0] tbl_wdata;
  logic [1:0] tbl_rdata = 2'b00;
  logic       init_busy;
  logic [2:0] pending;
  logic [1:0] mem [64];
  int         total = 0;
  int         bad = 0;
  logic [1:0] exp_byp;

  bp_table_ctrl #(.IDX_W(6), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_ready(upd_ready),
    .lookup_valid(lookup_valid), .lookup_idx(lookup_idx),
    .lookup_rvalid(lookup_rvalid), .lookup_data(lookup_data),
    .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .tbl_rdata(tbl_rdata), .init_busy(init_busy), .pending(pending)
  );

  always #5 clk = ~clk;

  // Synchronous single-port table: reads return one cycle after the request.
  always @(posedge clk) begin
    if (tbl_en) begin
      if (tbl_we) mem[tbl_addr] <= tbl_wdata;
      else        tbl_rdata <= mem[tbl_addr];
    end
  end

  task automatic applyStimulus(input logic r, input logic uv, input logic [5:0] ui,
                               input logic ut, input logic lv, input logic [5:0] li);
    @(negedge clk);
    rst = r; upd_valid = uv; upd_idx = ui; upd_taken = ut;
    lookup_valid = lv; lookup_idx = li;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic checkSweep(input int push_at);
    for (int i = 0; i < 64; i++) begin
      if (i > 0) applyStimulus(1'b0, 1'(i == push_at), 6'd20, 1'b1, 1'b1, 6'(i));
      checkOutput("sweep_en", 32'(tbl_en), 1);
      checkOutput("sweep_we", 32'(tbl_we), 1);
      checkOutput("sweep_addr", 32'(tbl_addr), i);
      checkOutput("sweep_wdata", 32'(tbl_wdata), 2);
      checkOutput("sweep_busy", 32'(init_busy), 1);
      checkOutput("sweep_rvalid", 32'(lookup_rvalid), 0);
      checkOutput("sweep_pending", 32'(pending), (push_at >= 0 && i > push_at) ? 1 : 0);
    end
  endtask

  initial begin
`ifdef BP_TABLE_BYPASS_EN
    exp_byp = 2'b01;
`else
    exp_byp = 2'b10;
`endif
    $display("[TB] start");

    // Reset state
    applyStimulus(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
    checkOutput("rst_en", 32'(tbl_en), 0);
    checkOutput("rst_we", 32'(tbl_we), 0);
    checkOutput("rst_rvalid", 32'(lookup_rvalid), 0);
    checkOutput("rst_data", 32'(lookup_data), 0);
    checkOutput("rst_busy", 32'(init_busy), 1);
    checkOutput("rst_ready", 32'(upd_ready), 1);
    checkOutput("rst_pending", 32'(pending), 0);

    // Init sweep with lookups held high and one update queued late in the sweep
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 6'd3);
    checkSweep(62);
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
    checkOutput("init_done_busy", 32'(init_busy), 0);
    checkOutput("init_done_rvalid", 32'(lookup_rvalid), 0);
    checkOutput("q20_rd_en", 32'(tbl_en), 1);
    checkOutput("q20_rd_we", 32'(tbl_we), 0);
    checkOutput("q20_rd_addr", 32'(tbl_addr), 20);
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
    checkOutput("q20_wr_we", 32'(tbl_we), 1);
    checkOutput("q20_wr_addr", 32'(tbl_addr), 20);
    checkOutput("q20_wr_data", 32'(tbl_wdata), 3);
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
    checkOutput("q20_pending", 32'(pending), 0);
    checkOutput("q20_idle_en", 32'(tbl_en), 0);

    // Uncontended update idx 5 taken
    applyStimulus(1'b0, 1'b1, 6'd5, 1'b1, 1'b0, 6'd0);
    checkOutput("u5_ready", 32'(upd_ready), 1);
    checkOutput("u5_t_en", 32'(tbl_en), 0);
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
    checkOutput("u5_rd_en", 32'(tbl_en), 1);
    checkOutput("u5_rd_we", 32'(tbl_we), 0);
    checkOutput("u5_rd_addr", 32'(tbl_addr), 5);
    checkOutput("u5_pending", 32'(pending), 1);
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
    checkOutput("u5_wr_we", 32'(tbl_we), 1);
    checkOutput("u5_wr_addr", 32'(tbl_addr), 5);
    checkOutput("u5_wr_data", 32'(tbl_wdata), 3);
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
    checkOutput("u5_pending_done", 32'(pending), 0);
    checkOutput("u5_idle_en", 32'(tbl_en), 0);

    // Update idx 9 not-taken with lookups contending from READ for three cycles
    applyStimulus(1'b0, 1'b1, 6'd9, 1'b0, 1'b0, 6'd0);
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
    checkOutput("u9_rd_addr", 32'(tbl_addr), 9);
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 6'd7);
    checkOutput("u9_read_lk_we", 32'(tbl_we), 0);
    checkOutput("u9_read_lk_addr", 32'(tbl_addr), 7);
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 6'd9);
    checkOutput("u9_w1_we", 32'(tbl_we), 0);
    checkOutput("u9_w1_addr", 32'(tbl_addr), 9);
    checkOutput("u9_w1_rvalid", 32'(lookup_rvalid), 1);
    checkOutput("u9_w1_data", 32'(lookup_data), 2);
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 6'd9);
    checkOutput("u9_w2_we", 32'(tbl_we), 0);
    checkOutput("u9_w2_rvalid", 32'(lookup_rvalid), 1);
    checkOutput("u9_w2_data", 32'(lookup_data), 32'(exp_byp));
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
    checkOutput("u9_wr_en", 32'(tbl_en), 1);
    checkOutput("u9_wr_we", 32'(tbl_we), 1);
    checkOutput("u9_wr_addr", 32'(tbl_addr), 9);
    checkOutput("u9_wr_data", 32'(tbl_wdata), 1);
    checkOutput("u9_w3_rvalid", 32'(lookup_rvalid), 1);
    checkOutput("u9_w3_data", 32'(lookup_data), 32'(exp_byp));
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
    checkOutput("u9_end_rvalid", 32'(lookup_rvalid), 0);
    checkOutput("u9_end_pending", 32'(pending), 0);
    checkOutput("u9_mem", 32'(mem[9]), 1);

    // Five back-to-back updates under continuous lookups
    applyStimulus(1'b0, 1'b1, 6'd1, 1'b1, 1'b1, 6'd0);
    checkOutput("bb0_ready", 32'(upd_ready), 1);
    applyStimulus(1'b0, 1'b1, 6'd2, 1'b1, 1'b1, 6'd0);
    checkOutput("bb1_pending", 32'(pending), 1);
    applyStimulus(1'b0, 1'b1, 6'd3, 1'b1, 1'b1, 6'd0);
    checkOutput("bb2_pending", 32'(pending), 2);
    applyStimulus(1'b0, 1'b1, 6'd4, 1'b1, 1'b1, 6'd0);
    checkOutput("bb3_pending", 32'(pending), 3);
    checkOutput("bb3_ready", 32'(upd_ready), 1);
    applyStimulus(1'b0, 1'b1, 6'd6, 1'b1, 1'b1, 6'd0);
    checkOutput("bb4_pending", 32'(pending), 4);
    checkOutput("bb4_ready", 32'(upd_ready), 0);
    applyStimulus(1'b0, 1'b1, 6'd6, 1'b1, 1'b1, 6'd0);
    checkOutput("bb5_ready", 32'(upd_ready), 0);
    checkOutput("bb5_pending", 32'(pending), 4);
    checkOutput("bb5_we", 32'(tbl_we), 0);
    applyStimulus(1'b0, 1'b1, 6'd6, 1'b1, 1'b0, 6'd0);
    checkOutput("bb6_rd_addr", 32'(tbl_addr), 1);
    checkOutput("bb6_rd_we", 32'(tbl_we), 0);
    applyStimulus(1'b0, 1'b1, 6'd6, 1'b1, 1'b0, 6'd0);
    checkOutput("bb7_wr_addr", 32'(tbl_addr), 1);
    checkOutput("bb7_wr_data", 32'(tbl_wdata), 3);
    checkOutput("bb7_ready_on_pop", 32'(upd_ready), 0);
    checkOutput("bb7_pending", 32'(pending), 4);
    applyStimulus(1'b0, 1'b1, 6'd6, 1'b1, 1'b0, 6'd0);
    checkOutput("bb8_pending", 32'(pending), 3);
    checkOutput("bb8_ready", 32'(upd_ready), 1);
    checkOutput("bb8_rd_addr", 32'(tbl_addr), 2);
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
    checkOutput("bb9_pending", 32'(pending), 4);
    checkOutput("bb9_wr_addr", 32'(tbl_addr), 2);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
    checkOutput("bb_drain_pending", 32'(pending), 0);
    checkOutput("bb_mem3", 32'(mem[3]), 3);
    checkOutput("bb_mem4", 32'(mem[4]), 3);
    checkOutput("bb_mem6", 32'(mem[6]), 3);

    // Reset while in WRITE with three updates queued
    applyStimulus(1'b0, 1'b1, 6'd12, 1'b0, 1'b0, 6'd0);
    applyStimulus(1'b0, 1'b1, 6'd13, 1'b0, 1'b0, 6'd0);
    checkOutput("rw_rd_addr", 32'(tbl_addr), 12);
    applyStimulus(1'b0, 1'b1, 6'd14, 1'b0, 1'b1, 6'd5);
    checkOutput("rw_read_we", 32'(tbl_we), 0);
    checkOutput("rw_read_pending", 32'(pending), 2);
    applyStimulus(1'b1, 1'b0, 6'd0, 1'b0, 1'b1, 6'd5);
    checkOutput("rw_write_pending", 32'(pending), 3);
    checkOutput("rw_rst_en", 32'(tbl_en), 0);
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 6'd5);
    checkOutput("rw_after_pending", 32'(pending), 0);
    checkOutput("rw_after_ready", 32'(upd_ready), 1);
    checkOutput("rw_after_data", 32'(lookup_data), 0);
    checkSweep(-1);
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
    checkOutput("rw_done_busy", 32'(init_busy), 0);
    checkOutput("rw_done_en", 32'(tbl_en), 0);
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
    checkOutput("rw_quiet_en", 32'(tbl_en), 0);
    checkOutput("rw_mem12", 32'(mem[12]), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bp_table_ctrl.md
BP_TABLE_CTRL -- requirements
Module: bp_table_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- IDX_W, 6, pattern-table index width; table holds 2^IDX_W 2-bit counters.
- FIFO_DEPTH, 4, update-queue entries (power of 2).

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, synchronous active-high reset.
- upd_valid, in, 1, resolved-branch update request.
- upd_idx, in, IDX_W, table index to update.
- upd_taken, in, 1, actual branch outcome.
- upd_ready, out, 1, queue can accept an update.
- lookup_valid, in, 1, fetch-stage read request (priority requester).
- lookup_idx, in, IDX_W, fetch read index.
- lookup_rvalid, out, 1, lookup data valid; the cycle after an accepted lookup.
- lookup_data, out, 2, counter value returned to fetch.
- tbl_en, out, 1, table port enable.
- tbl_we, out, 1, table write enable.
- tbl_addr, out, IDX_W, table address.
- tbl_wdata, out, 2, table write data.
- tbl_rdata, in, 2, table read data; synchronous, valid one cycle after tbl_en && !tbl_we.
- init_busy, out, 1, initialization sweep in progress.
- pending, out, log2(FIFO_DEPTH)+1, queued update count.

Function
REQ-003 The block SHALL own a single-port table and arbitrate it between fetch lookups and queued updates, with lookups having strict priority once INIT is finished.
REQ-004 The FSM SHALL have states INIT, IDLE, READ and WRITE.
REQ-005 INIT: one write per cycle to addresses 0..2^IDX_W-1 with wdata 2'b10 (weakly taken). Address 0 is written in the first cycle after rst deasserts. After the last address, go to IDLE; init_busy SHALL drop to 0 on the following cycle.
REQ-006 In INIT, lookups SHALL be ignored (lookup_rvalid=0), while updates SHALL still be queued.
REQ-007 Outside INIT, lookup_valid=1 SHALL drive tbl_en=1, tbl_we=0, tbl_addr=lookup_idx; lookup_rvalid=1 the next cycle with lookup_data=tbl_rdata (except REQ-017).
REQ-008 IDLE with queue non-empty and lookup_valid=0: issue tbl_en=1, tbl_we=0, tbl_addr=head idx; go to READ.
REQ-009 READ: compute new = saturating update of tbl_rdata (taken: +1, max 3; not-taken: -1, min 0) and register it.
- If lookup_valid=0: write new to head idx in the same cycle, pop the queue, go to IDLE.
- Otherwise: go to WRITE.
REQ-010 WRITE: hold the registered value; write and pop on the first cycle with lookup_valid=0, then go to IDLE.
REQ-011 Uncontended update latency: accepted in cycle t, read in t+1, write and pop in t+2.
REQ-012 Queue: FIFO order; push on upd_valid && upd_ready; upd_ready = !full. A pop in the same cycle SHALL NOT enable a push when the queue is full.
REQ-013 A simultaneous push and pop SHALL leave pending unchanged. Queue pointers SHALL wrap modulo FIFO_DEPTH.
REQ-014 Updates to the same index SHALL be applied in order. Each read follows the previous write by at least one cycle, so no read-after-write hazard exists inside the block.

Reset
REQ-015 rst=1 (including mid-INIT, READ or WRITE) SHALL give:
- state INIT, sweep address 0;
- queue empty, pending=0;
- in-flight update discarded;
- tbl_en=0, tbl_we=0, lookup_rvalid=0, lookup_data=0;
- init_busy=1, upd_ready=1.
REQ-016 All state SHALL be reset synchronously; no asynchronous reset logic SHALL exist.

Configuration
REQ-017 Macro BP_TABLE_BYPASS_EN:
- Defined: a lookup accepted while in WRITE whose lookup_idx equals the pending write index SHALL return the registered new value on lookup_data.
- Undefined: lookup_data is always tbl_rdata (stale value permitted).

Verification
REQ-018 Reset release, IDX_W=6 -> 64 consecutive writes of 2'b10 to addresses 0..63; init_busy=0 in cycle 64; no reads occur during the sweep.
REQ-019 After INIT, one update (idx 5, taken), no lookups -> read addr 5 in t+1; write 2'b11 to addr 5 in t+2; pending returns to 0.
REQ-020 Update idx 9 not-taken, with lookup_valid held high for 3 cycles starting at READ -> WRITE held 3 cycles; write 2'b01 on the 4th cycle; three lookup_rvalid pulses.
REQ-021 Five back-to-back updates, lookup_valid=1 throughout -> upd_ready=0 after 4 accepted; the 5th is held until the first pop.
REQ-022 Assert rst while in WRITE with 3 queued -> pending=0 next cycle; sweep restarts at address 0; the discarded write is never issued.
REQ-023 BP_TABLE_BYPASS_EN defined, lookup idx 9 during WRITE to idx 9 -> lookup_data equals the pending value; with the macro undefined -> lookup_data equals tbl_rdata.
